fixed_point: RTL and testbench

- Registered signed fixed-point arithmetic unit.
- Takes two signed Q(WIDTH-FRAC).FRAC operands, default Q2.6, and produces their sum, difference, product and quotient.
- All four results are registered with a 1-cycle latency.
- Used as a reference arithmetic block for fixed-point datapaths, e.g. the classifier MAC and normalisation stages.

---
 rtl/fixed_point.sv | 77 +++++++
 tb/tb_fixed_point.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fixed_point.sv
// Registered signed fixed-point add/sub/mul/div of two Q(WIDTH-FRAC).FRAC operands.
// 1-cycle latency, accepts new operands every cycle, no backpressure.
module fixed_point #(
   parameter int WIDTH = 8,
   parameter int FRAC  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH:0]     sum_ab,
   output logic [WIDTH:0]     diff_ab,
   output logic [2*WIDTH-1:0] prod_ab,
   output logic [2*WIDTH-1:0] quot_ab
);

   localparam int QW = 2 * WIDTH;

   logic [WIDTH:0]       a_ext;
   logic [WIDTH:0]       b_ext;
   logic [WIDTH:0]       sum_c;
   logic [WIDTH:0]       diff_c;
   logic signed [QW-1:0] prod_c;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [QW-1:0]        num_mag;
   logic [QW-1:0]        q_mag;
   logic [QW-1:0]        quot_c;
   logic [WIDTH:0]       rem;
   logic                 neg_q;

   assign a_ext  = {a[WIDTH-1], a};
   assign b_ext  = {b[WIDTH-1], b};
   assign sum_c  = a_ext + b_ext;
   assign diff_c = a_ext - b_ext;
   assign prod_c = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

   // Divide on magnitudes; 0 - x yields the correct unsigned magnitude even for the most negative value.
   assign a_mag   = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
   assign b_mag   = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
   assign num_mag = {{WIDTH{1'b0}}, a_mag} << FRAC;
   assign neg_q   = a[WIDTH-1] ^ b[WIDTH-1];

   always_comb begin
      rem   = '0;
      q_mag = '0;
      for (int i = QW - 1; i >= 0; i--) begin
         rem = {rem[WIDTH-1:0], num_mag[i]};
         if (rem >= {1'b0, b_mag}) begin
            rem      = rem - {1'b0, b_mag};
            q_mag[i] = 1'b1;
         end
      end
   end

   always_comb begin
      quot_c = neg_q ? ({QW{1'b0}} - q_mag) : q_mag;
      if (b == '0) begin
         quot_c = a[WIDTH-1] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_ab  <= '0;
         diff_ab <= '0;
         prod_ab <= '0;
         quot_ab <= '0;
      end else begin
         sum_ab  <= sum_c;
         diff_ab <= diff_c;
         prod_ab <= prod_c;
         quot_ab <= quot_c;
      end
   end

endmodule

// File: tb/tb_fixed_point.sv
// Directed and random checks of fixed_point at default Q2.6.
module tb_fixed_point;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [8:0]  sum_ab;
   logic [8:0]  diff_ab;
   logic [15:0] prod_ab;
   logic [15:0] quot_ab;

   int compared   = 0;
   int mismatched = 0;

   fixed_point #(.WIDTH(8), .FRAC(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .sum_ab  (sum_ab),
      .diff_ab (diff_ab),
      .prod_ab (prod_ab),
      .quot_ab (quot_ab)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [8:0] es, input logic [8:0] ed,
                            input logic [15:0] ep, input logic [15:0] eq);
      check({tag, ".sum"},  {7'd0, sum_ab},  {7'd0, es});
      check({tag, ".diff"}, {7'd0, diff_ab}, {7'd0, ed});
      check({tag, ".prod"}, prod_ab, ep);
      check({tag, ".quot"}, quot_ab, eq);
   endtask

   // Independent reference using integer arithmetic (truncating division).
   task automatic check_model(input string tag, input logic [7:0] ma, input logic [7:0] mb);
      int sa, sb, s, d, p, q;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      s  = sa + sb;
      d  = sa - sb;
      p  = sa * sb;
      if (sb == 0) q = (sa < 0) ? -32768 : 32767;
      else         q = (sa * 64) / sb;
      check_all(tag, s[8:0], d[8:0], p[15:0], q[15:0]);
   endtask

   logic [7:0] pa, pb;

   initial begin
      rst = 1'b1;
      a   = 8'hEC;
      b   = 8'h16;

      // Outputs stay zero while reset is held, even with live operands.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("reset%0d", i), {sum_ab[7:0], prod_ab[7:0] | quot_ab[7:0] | diff_ab[7:0]}
               | {7'd0, sum_ab[8] | diff_ab[8]} | (prod_ab[15:8] | quot_ab[15:8]), 16'h0000);
      end
      check_all("reset_full", 9'h000, 9'h000, 16'h0000, 16'h0000);

      rst = 1'b0;
      @(negedge clk);
      check_all("ec_16_first", 9'h002, 9'h1D6, 16'b1111_1110_0100_1000, 16'hFFC6);
      repeat (9) @(negedge clk);
      check_all("ec_16_hold", 9'h002, 9'h1D6, 16'hFE48, 16'hFFC6);

      a = 8'h7F; b = 8'h7F;
      @(negedge clk);
      check_all("max_max", 9'h0FE, 9'h000, 16'h3F01, 16'h0040);

      a = 8'h80; b = 8'h80;
      @(negedge clk);
      check_all("min_min", 9'h100, 9'h000, 16'h4000, 16'h0040);

      a = 8'h80; b = 8'hC0;            // -2 / -1 = 2.0
      @(negedge clk);
      check_all("min_div_m1", 9'h140, 9'h1C0, 16'h2000, 16'h0080);

      a = 8'h40; b = 8'h00;
      @(negedge clk);
      check_all("div0_pos", 9'h040, 9'h040, 16'h0000, 16'h7FFF);

      a = 8'hC0; b = 8'h00;
      @(negedge clk);
      check_all("div0_neg", 9'h1C0, 9'h1C0, 16'h0000, 16'h8000);

      a = 8'h00; b = 8'h00;
      @(negedge clk);
      check_all("div0_zero", 9'h000, 9'h000, 16'h0000, 16'h7FFF);

      a = 8'h20; b = 8'hE0;            // 0.5 / -0.5 = -1.0
      @(negedge clk);
      check_all("half_neg", 9'h000, 9'h040, 16'hFC00, 16'hFFC0);

      // Back-to-back random traffic: each edge reflects the previous edge's operands.
      a = 8'($urandom); b = 8'($urandom);
      pa = a; pb = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         check_model($sformatf("rand%0d", i), pa, pb);
         a = 8'($urandom);
         b = (i % 17 == 0) ? 8'h00 : 8'($urandom);
         pa = a; pb = b;
      end

      // Single-cycle reset pulse in the middle of traffic.
      rst = 1'b1;
      @(negedge clk);
      check_all("midrst", 9'h000, 9'h000, 16'h0000, 16'h0000);
      rst = 1'b0;
      a = 8'h9B; b = 8'h33;
      pa = a; pb = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_model($sformatf("post_rst%0d", i), pa, pb);
         a = 8'($urandom); b = 8'($urandom);
         pa = a; pb = b;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
